fsm_1: RTL and testbench

- Serial sequence detector. Moore finite-state machine with a 1-bit serial input and a 1-bit detect flag.
- Samples `in` on every rising edge of `clk`.
- Asserts `q` for one cycle after the bit pattern 1-1-0-1 has been received, oldest bit first. Overlapping occurrences are detected.
- Used as a small control/pattern-recognition leaf block. It has no handshake and no backpressure.

---
 rtl/fsm_1.sv | 66 ++++++
 tb/tb_fsm_1.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fsm_1.sv
// -----------------------------------------------------------------------------
// fsm_1 -- serial "1101" sequence detector (Moore FSM)
//
// Shifts in one bit per rising clk edge and raises q for exactly one cycle
// once the pattern 1-1-0-1 (oldest bit first) has been received.
// Overlapping occurrences are detected, e.g. 1101101 yields two pulses.
//
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous, active-high reset; returns the FSM to IDLE, q low
//   in  : serial data bit, sampled on each rising clk edge
//   q   : detect flag, registered, high for one cycle per completed 1101
// -----------------------------------------------------------------------------
module fsm_1 (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic q
);

    // Each state names the longest pattern prefix currently matched.
    typedef enum logic [2:0] {
        IDLE = 3'd0,   // no useful prefix
        S1   = 3'd1,   // "1"
        S11  = 3'd2,   // "11"
        S110 = 3'd3,   // "110"
        DET  = 3'd4    // "1101" complete
    } state_t;

    state_t state;
    state_t next_state;

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a branch is added or forgotten.
        next_state = IDLE;
        case (state)
            IDLE: next_state = in ? S1   : IDLE;
            S1:   next_state = in ? S11  : IDLE;
            // Extra leading 1s keep us in S11: "111" still ends in "11".
            S11:  next_state = in ? S11  : S110;
            S110: next_state = in ? DET  : IDLE;
            // Overlap: after "1101", a further 1 leaves "11" as a valid prefix.
            DET:  next_state = in ? S11  : IDLE;
            // The three unused codes recover to IDLE regardless of in.
            default: next_state = IDLE;
        endcase
    end

    // q is taken from next_state so it is high exactly while state == DET,
    // yet comes straight from a flop with no path from in to q.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: reset is synchronous here; only the control state and the
            // output flop need it, there is no storage array to clear.
            state <= IDLE;
            q     <= 1'b0;
        end else begin
            state <= next_state;
            q     <= (next_state == DET);
        end
    end

endmodule

// File: tb/tb_fsm_1.sv
// -----------------------------------------------------------------------------
// tb_fsm_1 -- self-checking bench for the fsm_1 "1101" sequence detector.
//
// A table of {rst, in, expected q} records covers reset, basic detect,
// overlap, near misses and reset mid-pattern. A random soak then compares q
// against a 4-bit shift-register reference and checks q is never high on two
// consecutive cycles.
// -----------------------------------------------------------------------------
module tb_fsm_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic q;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_1 dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .q   (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  rst;
        logic  in;
        logic  exp_q;
        string tag;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [2:0] actual,
                         input logic [2:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge, let the rising edge happen, then
    // sample 1 time unit later so outputs have settled.
    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst = r;
        in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic b, input logic e,
                       input string tag);
        vec_t v;
        v.rst   = r;
        v.in    = b;
        v.exp_q = e;
        v.tag   = tag;
        vecs.push_back(v);
    endtask

    logic [3:0] hist;
    logic       prev_q;
    logic       exp_q;
    logic       bit_v;

    initial begin
        // Reset: 2 edges with rst high and random in.
        add(1'b1, 1'($urandom_range(0, 1)), 1'b0, "reset0");
        add(1'b1, 1'($urandom_range(0, 1)), 1'b0, "reset1");
        // Basic detect: 1,1,0,1,0,0 -> pulse after edge 4 only.
        add(0, 1, 0, "basic1"); add(0, 1, 0, "basic2");
        add(0, 0, 0, "basic3"); add(0, 1, 1, "basic4");
        add(0, 0, 0, "basic5"); add(0, 0, 0, "basic6");
        // Overlap: 1,1,0,1,1,0,1 -> pulses after edges 4 and 7.
        add(0, 1, 0, "ovl1"); add(0, 1, 0, "ovl2"); add(0, 0, 0, "ovl3");
        add(0, 1, 1, "ovl4"); add(0, 1, 0, "ovl5"); add(0, 0, 0, "ovl6");
        add(0, 1, 1, "ovl7");
        // Reset while q is high: q must drop on that edge.
        add(1, 1, 0, "rst_while_q");
        // Near misses: 1,0,1,1,1,0,0,1,1,0,1 -> one pulse at the end.
        add(0, 1, 0, "near1"); add(0, 0, 0, "near2"); add(0, 1, 0, "near3");
        add(0, 1, 0, "near4"); add(0, 1, 0, "near5"); add(0, 0, 0, "near6");
        add(0, 0, 0, "near7"); add(0, 1, 0, "near8"); add(0, 1, 0, "near9");
        add(0, 0, 0, "near10"); add(0, 1, 1, "near11");
        // Reset mid-pattern: 1,1,0, rst, 1 -> no pulse; then 1,1,0,1 -> pulse.
        add(1, 0, 0, "mid_pre_rst");
        add(0, 1, 0, "mid1"); add(0, 1, 0, "mid2"); add(0, 0, 0, "mid3");
        add(1, 1, 0, "mid_rst"); add(0, 1, 0, "mid4");
        add(0, 1, 0, "mid5"); add(0, 1, 0, "mid6"); add(0, 0, 0, "mid7");
        add(0, 1, 1, "mid8");
        // Long run of leading 1s: 1,1,1,1,0,1 -> pulse at the end.
        add(1, 0, 0, "run_rst");
        add(0, 1, 0, "run1"); add(0, 1, 0, "run2"); add(0, 1, 0, "run3");
        add(0, 1, 0, "run4"); add(0, 0, 0, "run5"); add(0, 1, 1, "run6");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].in);
            check({vecs[i].tag, "_q"}, 3'(q), 3'(vecs[i].exp_q));
            if (vecs[i].rst)
                check({vecs[i].tag, "_state"}, 3'(dut.state), 3'd0);
        end

        // Random soak against a shift-register reference.
        step(1'b1, 1'b0);
        check("soak_reset_q", 3'(q), 3'd0);
        hist   = 4'b0000;
        prev_q = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bit_v = 1'($urandom_range(0, 1));
            step(1'b0, bit_v);
            hist  = {hist[2:0], bit_v};
            exp_q = (hist == 4'b1101);
            check($sformatf("soak_q_%0d", i), 3'(q), 3'(exp_q));
            check($sformatf("soak_b2b_%0d", i), 3'(prev_q & q), 3'd0);
            prev_q = q;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
